// File: rtl/uart_pkg.sv
// Shared constants for the UART program loader: RX FSM encoding,
// word packing geometry and the default bit period.
package uart_pkg;

    localparam int BYTES_PER_WORD       = 4;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    typedef logic [1:0] rx_state_t;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, mid-bit sampling FSM, one-cycle
// byte_valid strobe and one-cycle frame-error strobe.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] rx_byte_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       sync_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             recover_q, recover_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rx;

    assign rx           = sync_q[1];
    assign byte_valid_o = valid_q;
    assign rx_byte_o    = shift_q;
    assign frame_err_o  = ferr_q;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], rx_i};
    end

    // RX FSM: half-bit wait to centre on the start bit, then whole-bit steps.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        recover_d = recover_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    // A line that is high again mid start bit was a glitch.
                    state_d = rx ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (recover_q) begin
                    // Bad stop bit: hold off until the line idles again.
                    if (rx) begin
                        recover_d = 1'b0;
                        state_d   = RX_IDLE;
                    end
                end else if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx) begin
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d    = 1'b1;
                        recover_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            recover_q <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            recover_q <= recover_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Program loader: packs received UART bytes little-endian into 32-bit words,
// writes them to consecutive imem addresses, then releases the CPU.
module uart_prog_loader
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CELL_NUMBERS = 32,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_run,
    output logic              load_done,
    output logic              frame_err
);

    localparam int BC_W = $clog2(BYTES_PER_WORD);
    localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELL_NUMBERS - 1);

    logic              byte_valid;
    logic [7:0]        rx_byte;
    logic              ferr_stb;

    logic [BC_W-1:0]   byte_cnt_q;
    logic [31:0]       word_q;
    logic [ADDR_W-1:0] word_idx_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              load_done_q;
    logic              cpu_run_q;
    logic              frame_err_q;
    logic              accept;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (uart_rx),
        .byte_valid_o(byte_valid),
        .rx_byte_o   (rx_byte),
        .frame_err_o (ferr_stb)
    );

    // Bytes are dropped once the final write has been issued.
    assign accept = byte_valid && !cpu_run_q && !load_done_q;

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign load_done  = load_done_q;
    assign cpu_run    = cpu_run_q;
    assign frame_err  = frame_err_q;

    // Byte packing and word write; the write strobe follows the last byte by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_q   <= '0;
            word_q       <= 32'h0;
            word_idx_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'h0;
            load_done_q  <= 1'b0;
        end else begin
            imem_we_q   <= 1'b0;
            load_done_q <= 1'b0;
            if (accept) begin
                byte_cnt_q                  <= byte_cnt_q + BC_W'(1);
                word_q[8*byte_cnt_q +: 8]   <= rx_byte;
                if (byte_cnt_q == LAST_BYTE) begin
                    imem_we_q    <= 1'b1;
                    imem_addr_q  <= word_idx_q;
                    imem_wdata_q <= {rx_byte, word_q[23:0]};
                    load_done_q  <= (word_idx_q == LAST_ADDR);
                    word_idx_q   <= word_idx_q + ADDR_W'(1);
                end
            end
        end
    end

    // Sticky status: CPU release after the last write, framing error on any bad stop bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_run_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (load_done_q) cpu_run_q   <= 1'b1;
            if (ferr_stb)    frame_err_q <= 1'b1;
        end
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Sits between the board UART RX pin and the CPU core inside the CPU/UART top level.
- Receives the program image as 8N1 serial bytes and packs them little-endian into 32-bit words.
- Writes each word into instruction memory at consecutive word addresses.
- Releases the CPU to execute once CELL_NUMBERS words are loaded. This is the "load portion" that precedes instruction execution.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit (≥4, even).
- CELL_NUMBERS, 32, number of 32-bit words in the program image.
- ADDR_W, 8, imem word-address width; CELL_NUMBERS ≤ 2^ADDR_W.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- uart_rx  input  1  serial line; idle high; asynchronous to clk.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  packed instruction word.
- cpu_run  output  1  high = CPU released from hold; low = CPU held in reset.
- load_done  output  1  one-cycle pulse when the last word is written.
- frame_err  output  1  sticky; set on a bad stop bit.

Behaviour:
- Reset (rst=0, async): all outputs 0, word index 0, byte count 0, RX FSM in IDLE. Reset asserted mid-load aborts the load; after release, loading restarts at address 0.
- uart_rx synchronisation: 2-flop synchroniser, reset value 1 (idle). All RX decisions use the synchronised signal.
- RX FSM states:
  - IDLE: leave on falling edge (sync rx = 0) → START.
  - START: wait CLKS_PER_BIT/2 cycles. Sample: 0 → DATA; 1 → glitch, back to IDLE, no error.
  - DATA: 8 samples, each CLKS_PER_BIT apart, LSB first, shifted into a byte register → STOP.
  - STOP: after CLKS_PER_BIT, sample. 1 → byte_valid pulse for one cycle, → IDLE. 0 → frame_err=1, byte discarded, wait until sync rx = 1, → IDLE.
- Byte packing: byte k of a word (k = 0..3) goes to bits [8k+7:8k]. The byte counter is 2 bits and wraps.
- Word write: on the byte_valid of byte 3, the next cycle drives imem_we=1 with imem_addr = word index and imem_wdata = the packed word. The word index increments after the write. imem_addr and imem_wdata hold their values until the next write.
- Completion: the write to address CELL_NUMBERS−1 sets load_done for that same cycle. cpu_run goes 1 on the following cycle and stays 1 until reset.
- While cpu_run=1:
  - further RX bytes are decoded but ignored;
  - imem_we is never asserted;
  - frame_err still updates.
- frame_err does not abort the load. The partial word is unaffected; the faulty byte is simply missing. frame_err clears only on reset.
- Timing and edge cases:
  - Back-to-back frames with no idle gap are accepted.
  - Minimum spacing between imem_we pulses is 40·CLKS_PER_BIT.
  - A falling edge during STOP or its recovery is not detected until the FSM is back in IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - RX state encoding (RX_IDLE, RX_START, RX_DATA, RX_STOP) as a typedef/localparams;
  - BYTES_PER_WORD=4;
  - the default CLKS_PER_BIT constant.
- One sub-module, uart_rx_byte, owns the synchroniser, bit-timing counter, RX FSM, byte_valid/rx_byte outputs, and frame-error strobe.
- The top level does packing, addressing, and the cpu_run/load_done logic.

Test Plan (CLKS_PER_BIT=4, CELL_NUMBERS=2, ADDR_W=4):
- Reset state: hold rst=0 for 5 cycles with uart_rx=1 → all outputs 0. Release and idle 100 cycles → still 0.
- Normal load: send bytes 0x13,0x05,0x40,0x00,0x93,0xC5,0x45,0x00 → imem_we twice:
  - addr 0 with wdata 0x00400513;
  - addr 1 with wdata 0x0045C593, load_done pulse in the same cycle;
  - cpu_run=1 the next cycle.
- Start glitch: drive uart_rx low for 1 cycle, then a valid byte stream as above → no frame_err, identical writes.
- Framing error: send 0x13 with stop bit 0, then 0x13,0x05,0x40,0x00 → frame_err=1 and stays 1; first write is addr 0 with wdata 0x00400513.
- Reset mid-load: after 5 bytes, pulse rst low for 3 cycles, then send the full 8-byte image → writes restart at addr 0 with the correct words; cpu_run only after the second write.
- Post-load bytes: after cpu_run=1, send 4 more bytes → no imem_we, imem_addr stays 1, cpu_run stays 1.
